ansi_input_decoder: RTL and testbench



---
 rtl/ansi_input_decoder.sv | 198 +++++++++++++++++++
 tb/tb_ansi_input_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ansi_input_decoder.sv
// ansi_input_decoder: stdin byte stream -> key / terminal-report events.
// Optional SS3 (application cursor mode) arrows under ANSI_DEC_SS3_EN.
module ansi_input_decoder #(
    parameter int ESC_TIMEOUT = 8,
    parameter int MAX_LEN     = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       ev_valid,
    output logic [2:0] ev_type,
    output logic [7:0] ev_char,
    output logic [7:0] ev_p1,
    output logic [7:0] ev_p2,
    output logic       busy
);

    localparam int TW = $clog2(ESC_TIMEOUT + 1);
    localparam int LW = $clog2(MAX_LEN + 2);

    localparam logic [2:0] T_CHAR  = 3'd1;
    localparam logic [2:0] T_ARROW = 3'd2;
    localparam logic [2:0] T_ESC   = 3'd3;
    localparam logic [2:0] T_ALT   = 3'd4;
    localparam logic [2:0] T_CPR   = 3'd5;
    localparam logic [2:0] T_CSI   = 3'd6;
    localparam logic [2:0] T_ERR   = 3'd7;

`ifdef ANSI_DEC_SS3_EN
    typedef enum logic [1:0] {S_IDLE, S_ESC, S_CSI, S_SS3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ESC, S_CSI} state_t;
`endif

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [LW-1:0] len, len_n;
    logic [1:0]    idx, idx_n;
    logic [7:0]    p1, p1_n;
    logic [7:0]    p2, p2_n;
    logic          ev_set, p_set;
    logic [2:0]    ev_t;

    // Decimal accumulate, clamped at 255 instead of wrapping
    function automatic logic [7:0] acc(input logic [7:0] p,
                                       input logic [3:0] d);
        logic [11:0] s;
        s = 12'(p) * 12'd10 + 12'(d);
        return (s > 12'd255) ? 8'hFF : s[7:0];
    endfunction

    logic is_final, is_digit, is_semi, is_param, is_arrow;
    assign is_final = (in_byte >= 8'h40) && (in_byte <= 8'h7E);
    assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    assign is_semi  = (in_byte == 8'h3B);
    assign is_param = (in_byte >= 8'h20) && (in_byte <= 8'h3F);
    assign is_arrow = (in_byte >= 8'h41) && (in_byte <= 8'h44);

    always_comb begin
        state_n = state;
        timer_n = timer;
        len_n   = len;
        idx_n   = idx;
        p1_n    = p1;
        p2_n    = p2;
        ev_set  = 1'b0;
        p_set   = 1'b0;
        ev_t    = T_CHAR;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_byte == 8'h1B) begin
                        state_n = S_ESC;
                        timer_n = '0;
                    end else begin
                        ev_set = 1'b1;
                        ev_t   = T_CHAR;
                    end
                end
            end
            S_ESC: begin
                if (in_valid) begin
                    timer_n = '0;
                    if (in_byte == 8'h5B) begin
                        state_n = S_CSI;
                        p1_n    = '0;
                        p2_n    = '0;
                        idx_n   = '0;
                        len_n   = '0;
                    end else if (in_byte == 8'h1B) begin
                        ev_set = 1'b1;
                        ev_t   = T_ESC;
`ifdef ANSI_DEC_SS3_EN
                    end else if (in_byte == 8'h4F) begin
                        state_n = S_SS3;
`endif
                    end else begin
                        ev_set  = 1'b1;
                        ev_t    = T_ALT;
                        state_n = S_IDLE;
                    end
                end else if (timer == TW'(ESC_TIMEOUT - 1)) begin
                    ev_set  = 1'b1;
                    ev_t    = T_ESC;
                    state_n = S_IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_CSI: begin
                if (in_valid) begin
                    len_n = len + 1'b1;
                    if (is_final) begin
                        ev_set  = 1'b1;
                        p_set   = 1'b1;
                        state_n = S_IDLE;
                        if (is_arrow && idx == 2'd0)
                            ev_t = T_ARROW;
                        else if (in_byte == 8'h52)
                            ev_t = T_CPR;
                        else
                            ev_t = T_CSI;
                    end else if (is_param) begin
                        if (len >= LW'(MAX_LEN)) begin
                            ev_set  = 1'b1;
                            ev_t    = T_ERR;
                            state_n = S_IDLE;
                        end else if (is_semi) begin
                            idx_n = (idx == 2'd0) ? 2'd1 : 2'd2;
                        end else if (is_digit) begin
                            if (idx == 2'd0)
                                p1_n = acc(p1, in_byte[3:0]);
                            else if (idx == 2'd1)
                                p2_n = acc(p2, in_byte[3:0]);
                        end
                    end else if (in_byte == 8'h1B) begin
                        // Stray ESC aborts this sequence and opens the next
                        ev_set  = 1'b1;
                        ev_t    = T_ERR;
                        state_n = S_ESC;
                        timer_n = '0;
                    end else begin
                        ev_set  = 1'b1;
                        ev_t    = T_ERR;
                        state_n = S_IDLE;
                    end
                end
            end
`ifdef ANSI_DEC_SS3_EN
            S_SS3: begin
                if (in_valid) begin
                    ev_set  = 1'b1;
                    ev_t    = is_arrow ? T_ARROW : T_ERR;
                    state_n = S_IDLE;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            timer    <= '0;
            len      <= '0;
            idx      <= '0;
            p1       <= '0;
            p2       <= '0;
            ev_valid <= 1'b0;
            ev_type  <= '0;
            ev_char  <= '0;
            ev_p1    <= '0;
            ev_p2    <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            len      <= len_n;
            idx      <= idx_n;
            p1       <= p1_n;
            p2       <= p2_n;
            ev_valid <= ev_set;
            busy     <= (state_n != S_IDLE);
            if (ev_set) begin
                ev_type <= ev_t;
                ev_char <= (ev_t == T_ESC) ? 8'h1B : in_byte;
            end
            if (p_set) begin
                ev_p1 <= p1;
                ev_p2 <= p2;
            end
        end
    end

endmodule

// File: tb/tb_ansi_input_decoder.sv
// Bench for ansi_input_decoder: directed plan plus random byte stream
// checked every cycle against a buffer-based sequence parser model.
module tb_ansi_input_decoder;

    localparam int TMO = 8;
    localparam int MAXL = 12;
`ifdef ANSI_DEC_SS3_EN
    localparam bit SS3 = 1'b1;
`else
    localparam bit SS3 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       ev_valid;
    logic [2:0] ev_type;
    logic [7:0] ev_char;
    logic [7:0] ev_p1;
    logic [7:0] ev_p2;
    logic       busy;

    ansi_input_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
        .ev_valid(ev_valid), .ev_type(ev_type), .ev_char(ev_char),
        .ev_p1(ev_p1), .ev_p2(ev_p2), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    logic [7:0] pend[$];
    int         idle_cnt = 0;
    logic       e_valid = 0;
    logic [2:0] e_type = 0;
    logic [7:0] e_char = 0;
    logic [7:0] e_p1 = 0;
    logic [7:0] e_p2 = 0;
    logic       e_busy = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic emit(input logic [2:0] t, input logic [7:0] c);
        e_valid = 1'b1;
        e_type  = t;
        e_char  = c;
    endtask

    // Parse the buffered "ESC [ ..." text into up to two capped numbers
    task automatic finish_csi(input logic [7:0] fin);
        int v[2];
        int k;
        v[0] = 0; v[1] = 0; k = 0;
        for (int i = 2; i < pend.size(); i++) begin
            if (pend[i] == 8'h3B) begin
                if (k < 2) k++;
            end else if (pend[i] >= 8'h30 && pend[i] <= 8'h39 && k < 2) begin
                v[k] = v[k] * 10 + int'(pend[i] - 8'h30);
                if (v[k] > 255) v[k] = 255;
            end
        end
        if (fin >= 8'h41 && fin <= 8'h44 && k == 0) emit(3'd2, fin);
        else if (fin == 8'h52) emit(3'd5, fin);
        else emit(3'd6, fin);
        e_p1 = 8'(v[0]);
        e_p2 = 8'(v[1]);
    endtask

    task automatic model(input logic r, input logic v, input logic [7:0] b);
        e_valid = 1'b0;
        if (r) begin
            pend.delete();
            idle_cnt = 0;
            e_type = 0; e_char = 0; e_p1 = 0; e_p2 = 0;
        end else if (!v) begin
            if (pend.size() == 1) begin
                idle_cnt++;
                if (idle_cnt == TMO) begin
                    emit(3'd3, 8'h1B);
                    pend.delete();
                end
            end
        end else begin
            idle_cnt = 0;
            if (pend.size() == 0) begin
                if (b == 8'h1B) pend.push_back(b);
                else emit(3'd1, b);
            end else if (pend.size() == 1) begin
                if (b == 8'h5B || (SS3 && b == 8'h4F)) pend.push_back(b);
                else if (b == 8'h1B) emit(3'd3, 8'h1B);
                else begin
                    emit(3'd4, b);
                    pend.delete();
                end
            end else if (pend[1] == 8'h4F) begin
                emit((b >= 8'h41 && b <= 8'h44) ? 3'd2 : 3'd7, b);
                pend.delete();
            end else begin
                if (b >= 8'h40 && b <= 8'h7E) begin
                    finish_csi(b);
                    pend.delete();
                end else if (b >= 8'h20 && b <= 8'h3F) begin
                    if (pend.size() - 2 >= MAXL) begin
                        emit(3'd7, b);
                        pend.delete();
                    end else pend.push_back(b);
                end else if (b == 8'h1B) begin
                    emit(3'd7, b);
                    pend.delete();
                    pend.push_back(8'h1B);
                end else begin
                    emit(3'd7, b);
                    pend.delete();
                end
            end
        end
        e_busy = (pend.size() != 0);
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] b);
        rst = r; in_valid = v; in_byte = b;
        @(posedge clk);
        model(r, v, b);
        #1;
        chk("ev_valid", int'(ev_valid), int'(e_valid));
        chk("busy", int'(busy), int'(e_busy));
        chk("ev_type", int'(ev_type), int'(e_type));
        chk("ev_char", int'(ev_char), int'(e_char));
        chk("ev_p1", int'(ev_p1), int'(e_p1));
        chk("ev_p2", int'(ev_p2), int'(e_p2));
    endtask

    task automatic sb(input logic [7:0] b);
        step(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] rb;

    initial begin
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("reset_ev_valid", int'(ev_valid), 0);
        chk("reset_busy", int'(busy), 0);
        sb(8'h20); sb(8'h71); idle(2);
        sb(8'h1B); sb(8'h5B); sb(8'h41); idle(2);
        sb(8'h1B); sb(8'h5B); sb(8'h32); sb(8'h34); sb(8'h3B);
        sb(8'h38); sb(8'h30); sb(8'h52);
        chk("cpr_row", int'(ev_p1), 24);
        chk("cpr_col", int'(ev_p2), 80);
        sb(8'h1B); sb(8'h5B); sb(8'h39); sb(8'h39); sb(8'h39); sb(8'h52);
        chk("cpr_sat", int'(ev_p1), 255);
        sb(8'h1B); idle(TMO + 3);
        sb(8'h1B); sb(8'h1B); sb(8'h71); idle(1);
        sb(8'h1B); idle(TMO - 1); sb(8'h61); idle(1);
        sb(8'h1B); sb(8'h5B); sb(8'h33); sb(8'h0A); idle(1);
        sb(8'h1B); sb(8'h5B);
        for (int i = 0; i < MAXL + 1; i++) sb(8'h31);
        idle(1);
        sb(8'h1B); sb(8'h5B);
        for (int i = 0; i < MAXL; i++) sb(8'h31);
        sb(8'h48); idle(1);
        sb(8'h1B); sb(8'h5B); step(1'b1, 1'b0, 8'h00); idle(1);
        sb(8'h1B); sb(8'h4F); sb(8'h42); idle(1);
        sb(8'h1B); sb(8'h5B); sb(8'h35); sb(8'h1B); sb(8'h5B);
        sb(8'h31); sb(8'h3B); sb(8'h32); sb(8'h3B); sb(8'h39);
        sb(8'h7E); idle(1);
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 1) step(1'b1, 1'b0, 8'h00);
            else if (r < 3) idle(TMO + 1);
            else if (r < 25) idle(1);
            else begin
                case ($urandom_range(0, 11))
                    0, 1:    rb = 8'h1B;
                    2:       rb = 8'h5B;
                    3, 4:    rb = 8'h30 + 8'($urandom_range(0, 9));
                    5:       rb = 8'h3B;
                    6:       rb = 8'h41 + 8'($urandom_range(0, 3));
                    7:       rb = 8'h52;
                    8:       rb = 8'h4F;
                    9:       rb = 8'h20 + 8'($urandom_range(0, 15));
                    10:      rb = 8'($urandom_range(0, 255));
                    default: rb = 8'h0A;
                endcase
                sb(rb);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
